// File: rtl/shift_pkg.sv
// shift_pkg: command-word layout helpers for the shift command queue
package shift_pkg;
  localparam int DATA_LSB = 0;
  function automatic int cmd_width(input int n);
    return 2**n + n + 1;
  endfunction
  function automatic int amt_lsb(input int n);
    return DATA_LSB + 2**n;
  endfunction
  function automatic int lr_bit(input int n);
    return cmd_width(n) - 1;
  endfunction
endpackage

// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo: synchronous FIFO with wrap-bit pointers and combinational head word
module shift_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
    wr_ptr_d = clr ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + PW'(do_pop);
  end
  // storage is deliberately left out of reset; only pointers clear
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: command FIFO feeding an external barrel shifter with a registered valid/ready result
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2**N-1:0]        in_data,
  input  logic [N-1:0]           in_amt,
  input  logic                   in_lr,
  output logic [2**N-1:0]        sh_a,
  output logic [N-1:0]           sh_amt,
  output logic                   sh_lr,
  input  logic [2**N-1:0]        sh_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**N-1:0]        out_data,
  output logic                   out_lr,
  output logic [$clog2(DEPTH):0] level
);
  localparam int W  = 2**N;
  localparam int CW = cmd_width(N);
  localparam int AL = amt_lsb(N);
  localparam int LB = lr_bit(N);
  logic [CW-1:0] head;
  logic full, empty, issue;
  logic out_valid_q, out_valid_d, out_lr_q, out_lr_d;
  logic [W-1:0] out_data_q, out_data_d;
  assign in_ready  = !full;
  assign sh_a      = head[DATA_LSB +: W];
  assign sh_amt    = head[AL +: N];
  assign sh_lr     = head[LB];
  assign issue     = !empty && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lr    = out_lr_q;
  shift_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (in_valid && in_ready),
    .pop   (issue),
    .wdata ({in_lr, in_amt, in_data}),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );
  // a new issue refills the result register in the same cycle it is consumed
  always_comb begin
    out_valid_d = flush ? 1'b0 : issue ? 1'b1 : out_valid_q && !out_ready;
    out_data_d  = flush ? '0 : issue ? sh_y : out_data_q;
    out_lr_d    = flush ? 1'b0 : issue ? sh_lr : out_lr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lr_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lr_q    <= out_lr_d;
    end
  end
endmodule
